// File: rtl/main_ram_pkg.sv
// Shared definitions for the main RAM controller: FSM states, port ids, default timing.
package main_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned DEF_RD_WAIT  = 2;
  localparam int unsigned DEF_WR_PULSE = 1;

endpackage

// File: rtl/main_ram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, bit 0 = port A, bit 1 = port B.
module rr_arb2
  import main_ram_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (enable_i) begin
      if (req_a_i && req_b_i) begin
        grant_o = (last_grant_i == PORT_A) ? 2'b10 : 2'b01;
      end else begin
        grant_o = {req_b_i, req_a_i};
      end
    end
  end

endmodule

// File: rtl/main_ram_ctrl.sv
// Shares the asynchronous main RAM between CPU (port A) and DMA (port B) with registered strobes.
// Define MAIN_RAM_CTRL_TRACE_EN to print one line per completed access.
module main_ram_ctrl
  import main_ram_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned RD_WAIT    = DEF_RD_WAIT,
  parameter int unsigned WR_PULSE   = DEF_WR_PULSE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_ack,
  output logic                  busy,
  output logic                  _ram_cs,
  output logic                  _ram_oe,
  output logic                  _ram_w,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam int unsigned MAXW  = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  port_q, we_q, last_q;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q, a_rdata_q, b_rdata_q;
  logic                  cs_q, oe_q, w_q, a_ack_q, b_ack_q;

  rr_arb2 u_arb (
    .req_a_i      (a_req),
    .req_b_i      (b_req),
    .last_grant_i (last_q),
    .enable_i     (state_q == ST_IDLE),
    .grant_o      (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (grant != 2'b00) state_d = ST_SETUP;
      ST_SETUP: begin
        if (we_q) begin
          state_d = ST_WRITE;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else begin
          state_d = ST_READ;
          cnt_d   = CNT_W'(RD_WAIT - 1);
        end
      end
      ST_READ:  if (cnt_q == '0) state_d = ST_DONE;  else cnt_d = cnt_q - CNT_W'(1);
      ST_WRITE: if (cnt_q == '0) state_d = ST_HOLD;  else cnt_d = cnt_q - CNT_W'(1);
      ST_HOLD:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so pins never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      port_q    <= PORT_A;
      we_q      <= 1'b0;
      last_q    <= PORT_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      cs_q      <= 1'b1;
      oe_q      <= 1'b1;
      w_q       <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && grant != 2'b00) begin
        port_q <= grant[1];
        last_q <= grant[1];
        we_q   <= grant[1] ? b_we : a_we;
        addr_q <= grant[1] ? b_addr : a_addr;
        if (grant[1] ? b_we : a_we) wdata_q <= grant[1] ? b_wdata : a_wdata;
      end
      if (state_q == ST_READ && cnt_q == '0) begin
        if (port_q == PORT_A) a_rdata_q <= ram_rdata;
        else                  b_rdata_q <= ram_rdata;
      end
      cs_q    <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      oe_q    <= (state_d != ST_READ);
      w_q     <= (state_d != ST_WRITE);
      a_ack_q <= (state_d == ST_DONE) && (port_q == PORT_A);
      b_ack_q <= (state_d == ST_DONE) && (port_q == PORT_B);
    end
  end

`ifdef MAIN_RAM_CTRL_TRACE_EN
  logic [WIDTH-1:0] trace_data;
  assign trace_data = we_q ? wdata_q : ((port_q == PORT_A) ? a_rdata_q : b_rdata_q);
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_DONE)
      $display("main_ram_ctrl trace: port %s %s addr %0d data %b 0x%h",
               (port_q == PORT_A) ? "A" : "B", we_q ? "W" : "R",
               addr_q, trace_data, trace_data);
  end
`else
  // default build carries no trace logic
`endif

  assign busy      = (state_q != ST_IDLE);
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign _ram_cs   = cs_q;
  assign _ram_oe   = oe_q;
  assign _ram_w    = w_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
